// File: rtl/ps2_keycode_if.sv
// Peripheral bus bundle for the PS/2 key-event stage (CPU side).
interface ps2_keycode_if;
   logic [31:0] addr_i;
   logic [31:0] data_o;
   logic [31:0] data_i;
   logic [1:0]  sel_i;
   logic        rd_i;
   logic        we_i;
   logic        ack_o;

   modport slave (
      input  addr_i, data_i, sel_i, rd_i, we_i,
      output data_o, ack_o
   );

   modport master (
      output addr_i, data_i, sel_i, rd_i, we_i,
      input  data_o, ack_o
   );
endinterface

// File: rtl/ps2_keycode.sv
// PS/2 key-event stage: pulls scan-code bytes from the receiver, folds E0/F0
// prefixes into 10-bit key events, skips the Pause (E1) tail, and queues events
// for the CPU. Optional build macro PS2_KEYCODE_TYPEMATIC_FILTER_EN suppresses
// auto-repeat make events of the most recently pressed key.
module ps2_keycode #(
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned PAUSE_SKIP = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             byte_avail_i,
   output logic             byte_rd_o,
   input  logic             byte_valid_i,
   input  logic [7:0]       byte_i,
   ps2_keycode_if.slave     bus,
   output logic             interrupt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned SW = $clog2(PAUSE_SKIP + 1);

   typedef struct packed {
      logic       brk;
      logic       ext;
      logic [7:0] code;
   } key_event_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DECODE
   } state_t;

   state_t          state;
   logic [7:0]      byte_q;
   logic            ext;
   logic            brk;
   logic [SW-1:0]   skip_cnt;
   logic [7:0]      drop_cnt;

   key_event_t      mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;

   logic            push_c;
   logic            pop_c;
   key_event_t      ev_c;
   logic            ext_nxt_c;
   logic            brk_nxt_c;
   logic [SW-1:0]   skip_nxt_c;
   logic            drop_inc_c;
   logic [CW-1:0]   count_nxt_c;
   logic [4:0]      cnt_sat_c;
   logic            drop_clr_c;

`ifdef PS2_KEYCODE_TYPEMATIC_FILTER_EN
   logic [8:0]      last_make;
   logic            last_valid;
   logic [8:0]      last_make_nxt_c;
   logic            last_valid_nxt_c;
`endif

   logic            unused_bus_c;
   assign unused_bus_c = ^{bus.addr_i[31:3], bus.addr_i[1:0], bus.data_i[31:1], bus.sel_i};

   // Fetch FSM: one pop request per byte, only while the event FIFO has room.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         byte_rd_o <= 1'b0;
         byte_q    <= 8'h00;
      end else begin
         case (state)
            S_IDLE: begin
               if (byte_avail_i && (count != CW'(DEPTH))) begin
                  state     <= S_REQ;
                  byte_rd_o <= 1'b1;
               end
            end
            S_REQ: begin
               byte_rd_o <= 1'b0;
               state     <= S_WAIT;
            end
            S_WAIT: begin
               if (byte_valid_i) begin
                  byte_q <= byte_i;
                  state  <= S_DECODE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Byte decode: prefix folding, Pause skip, error counting, event generation.
   always_comb begin
      push_c     = 1'b0;
      ev_c       = '0;
      ext_nxt_c  = ext;
      brk_nxt_c  = brk;
      skip_nxt_c = skip_cnt;
      drop_inc_c = 1'b0;
`ifdef PS2_KEYCODE_TYPEMATIC_FILTER_EN
      last_make_nxt_c  = last_make;
      last_valid_nxt_c = last_valid;
`endif
      if (state == S_DECODE) begin
         if (skip_cnt != '0) begin
            skip_nxt_c = skip_cnt - SW'(1);
         end else begin
            case (byte_q)
               8'hE1: begin
                  skip_nxt_c = SW'(PAUSE_SKIP);
                  push_c     = 1'b1;
                  ev_c       = '{brk: 1'b0, ext: 1'b1, code: 8'hE1};
               end
               8'hE0: ext_nxt_c = 1'b1;
               8'hF0: brk_nxt_c = 1'b1;
               8'h00, 8'hFF: begin
                  drop_inc_c = 1'b1;
                  ext_nxt_c  = 1'b0;
                  brk_nxt_c  = 1'b0;
               end
               8'hFA, 8'hAA, 8'hFE: ;
               default: begin
                  push_c    = 1'b1;
                  ev_c      = '{brk: brk, ext: ext, code: byte_q};
                  ext_nxt_c = 1'b0;
                  brk_nxt_c = 1'b0;
`ifdef PS2_KEYCODE_TYPEMATIC_FILTER_EN
                  if (!brk) begin
                     if (last_valid && (last_make == {ext, byte_q})) begin
                        push_c = 1'b0;
                     end else begin
                        last_make_nxt_c  = {ext, byte_q};
                        last_valid_nxt_c = 1'b1;
                     end
                  end else if (last_valid && (last_make == {ext, byte_q})) begin
                     last_valid_nxt_c = 1'b0;
                  end
`endif
               end
            endcase
         end
      end
   end

   // Decoder flag registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ext      <= 1'b0;
         brk      <= 1'b0;
         skip_cnt <= '0;
`ifdef PS2_KEYCODE_TYPEMATIC_FILTER_EN
         last_make  <= 9'h000;
         last_valid <= 1'b0;
`endif
      end else begin
         ext      <= ext_nxt_c;
         brk      <= brk_nxt_c;
         skip_cnt <= skip_nxt_c;
`ifdef PS2_KEYCODE_TYPEMATIC_FILTER_EN
         last_make  <= last_make_nxt_c;
         last_valid <= last_valid_nxt_c;
`endif
      end
   end

   // FIFO occupancy; a pop needs a read of the event register while non-empty.
   always_comb begin
      pop_c       = bus.rd_i && !bus.addr_i[2] && (count != '0);
      count_nxt_c = count;
      case ({push_c, pop_c})
         2'b10:   count_nxt_c = count + CW'(1);
         2'b01:   count_nxt_c = count - CW'(1);
         default: count_nxt_c = count;
      endcase
      cnt_sat_c  = (32'(count) > 32'd31) ? 5'd31 : 5'(count);
      drop_clr_c = bus.we_i && bus.addr_i[2] && bus.data_i[0];
   end

   // Event storage (no reset needed; pointers and count define contents).
   always_ff @(posedge clk) begin
      if (push_c) mem[wr_ptr] <= ev_c;
   end

   // FIFO pointers, count and interrupt.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         interrupt <= 1'b0;
      end else begin
         if (push_c) wr_ptr <= wr_ptr + AW'(1);
         if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
         count     <= count_nxt_c;
         interrupt <= (count_nxt_c != '0);
      end
   end

   // Receiver error counter, saturating; a CPU clear wins over a same-cycle increment.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drop_cnt <= 8'h00;
      end else if (drop_clr_c) begin
         drop_cnt <= 8'h00;
      end else if (drop_inc_c && (drop_cnt != 8'hFF)) begin
         drop_cnt <= drop_cnt + 8'h01;
      end
   end

   // Bus response: one-cycle ack, read data held until the next read.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.ack_o  <= 1'b0;
         bus.data_o <= 32'h0000_0000;
      end else begin
         bus.ack_o <= bus.rd_i | bus.we_i;
         if (bus.rd_i) begin
            if (bus.addr_i[2]) begin
               bus.data_o <= {8'h00, drop_cnt, 11'h000, cnt_sat_c};
            end else if (count != '0) begin
               bus.data_o <= {1'b1, 21'h000000, mem[rd_ptr]};
            end else begin
               bus.data_o <= 32'h0000_0000;
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_keycode.sv
// Bench for ps2_keycode: directed scan-code sequences with literal expectations,
// then randomized bytes and bus traffic checked against a queue-based model.
module tb_ps2_keycode;

   localparam int unsigned DEPTH      = 16;
   localparam int unsigned PAUSE_SKIP = 7;

   logic       clk;
   logic       rst;
   logic       byte_avail_i;
   logic       byte_rd_o;
   logic       byte_valid_i;
   logic [7:0] byte_i;
   logic       interrupt;

   ps2_keycode_if bus();

   ps2_keycode #(.DEPTH(DEPTH), .PAUSE_SKIP(PAUSE_SKIP)) dut (
      .clk          (clk),
      .rst          (rst),
      .byte_avail_i (byte_avail_i),
      .byte_rd_o    (byte_rd_o),
      .byte_valid_i (byte_valid_i),
      .byte_i       (byte_i),
      .bus          (bus),
      .interrupt    (interrupt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Receiver byte buffer model
   logic [7:0] rx_q[$];
   int         rx_wait = 0;
   logic [7:0] rx_hold = 8'h00;

   // Behavioural model state
   int   mfifo[$];
   int   pend_ev[$];
   int   pend_ev_rdy[$];
   int   pend_drop_rdy[$];
   int   m_drop = 0;
   bit   m_ext = 0;
   bit   m_brk = 0;
   int   m_skip = 0;
   bit   lm_v = 0;
   int   lm = 0;
   bit   fetch_busy = 0;
   int   cyc = 0;

   bit          prev_rd = 0;
   bit          prev_avail = 0;
   int          pre_cnt = 0;
   logic [31:0] exp_data = 32'h0;
   bit          exp_ack = 0;
   bit          clr = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scan-code rules applied to one byte; resulting event/drop become visible at cycle rdy.
   function automatic void m_decode(input int b, input int rdy);
      int ev;
      int key;
      ev = -1;
      if (m_skip > 0) begin
         m_skip--;
         return;
      end
      case (b)
         'hE1: begin m_skip = PAUSE_SKIP; ev = 'h1E1; end
         'hE0: m_ext = 1;
         'hF0: m_brk = 1;
         'h00, 'hFF: begin pend_drop_rdy.push_back(rdy); m_ext = 0; m_brk = 0; end
         'hFA, 'hAA, 'hFE: ;
         default: begin
            key = (m_ext ? 256 : 0) + b;
            ev  = (m_brk ? 512 : 0) + key;
`ifdef PS2_KEYCODE_TYPEMATIC_FILTER_EN
            if (!m_brk) begin
               if (lm_v && lm == key) ev = -1;
               else begin lm = key; lm_v = 1; end
            end else if (lm_v && lm == key) begin
               lm_v = 0;
            end
`endif
            m_ext = 0;
            m_brk = 0;
         end
      endcase
      if (ev >= 0) begin
         pend_ev.push_back(ev);
         pend_ev_rdy.push_back(rdy);
      end
   endfunction

   function automatic logic [7:0] rand_byte();
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 25) begin
         case ($urandom_range(0, 7))
            0: return 8'hE0;
            1: return 8'hF0;
            2: return 8'hE1;
            3: return 8'h00;
            4: return 8'hFF;
            5: return 8'hFA;
            6: return 8'hAA;
            default: return 8'hFE;
         endcase
      end else if (r < 70) begin
         case ($urandom_range(0, 3))
            0: return 8'h1C;
            1: return 8'h1D;
            2: return 8'h75;
            default: return 8'h14;
         endcase
      end
      return 8'($urandom);
   endfunction

   // Receiver: answers each pop request after 1..3 cycles with the next byte.
   initial begin
      byte_valid_i = 1'b0;
      byte_i       = 8'h00;
      byte_avail_i = 1'b0;
      forever begin
         @(negedge clk);
         byte_valid_i = 1'b0;
         if (rx_wait > 0) begin
            rx_wait--;
            if (rx_wait == 0) begin
               byte_valid_i = 1'b1;
               byte_i       = rx_hold;
            end
         end else if (rst && byte_rd_o && rx_q.size() > 0) begin
            rx_hold = rx_q.pop_front();
            rx_wait = int'($urandom_range(1, 3));
         end
         byte_avail_i = (rx_q.size() != 0);
      end
   end

   // Model update on each clock edge, comparison against the DUT mid-cycle.
   initial begin
      wait (rst === 1'b1);
      forever begin
         @(posedge clk);
         cyc++;
         pre_cnt    = mfifo.size();
         prev_avail = byte_avail_i;
         clr        = 0;
         exp_ack    = bus.rd_i | bus.we_i;
         if (bus.rd_i) begin
            if (!bus.addr_i[2]) begin
               if (mfifo.size() > 0) exp_data = 32'h8000_0000 | 32'(mfifo.pop_front());
               else exp_data = 32'h0;
            end else begin
               exp_data = {8'h00, 8'(m_drop), 11'h000, 5'(pre_cnt > 31 ? 31 : pre_cnt)};
            end
         end
         if (bus.we_i && bus.addr_i[2] && bus.data_i[0]) clr = 1;
         while (pend_ev.size() > 0 && pend_ev_rdy[0] <= cyc) begin
            mfifo.push_back(pend_ev.pop_front());
            void'(pend_ev_rdy.pop_front());
         end
         while (pend_drop_rdy.size() > 0 && pend_drop_rdy[0] <= cyc) begin
            void'(pend_drop_rdy.pop_front());
            if (m_drop < 255) m_drop++;
         end
         if (clr) m_drop = 0;
         if (byte_valid_i) begin
            fetch_busy = 0;
            m_decode(int'(byte_i), cyc + 1);
         end
         @(negedge clk);
         chk("ack", 32'(bus.ack_o), 32'(exp_ack));
         chk("data", bus.data_o, exp_data);
         chk("irq", 32'(interrupt), 32'(mfifo.size() != 0));
         if (byte_rd_o) begin
            chk("rd_pulse", 32'(prev_rd), 32'd0);
            chk("rd_avail", 32'(prev_avail), 32'd1);
            chk("rd_room", 32'(pre_cnt < DEPTH), 32'd1);
            chk("rd_busy", 32'(fetch_busy), 32'd0);
            fetch_busy = 1;
         end
         prev_rd = byte_rd_o;
      end
   end

   task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
      @(negedge clk);
      bus.addr_i = a;
      bus.rd_i   = 1'b1;
      @(negedge clk);
      bus.rd_i = 1'b0;
      d = bus.data_o;
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] v);
      @(negedge clk);
      bus.addr_i = a;
      bus.data_i = v;
      bus.we_i   = 1'b1;
      @(negedge clk);
      bus.we_i = 1'b0;
   endtask

   function automatic bit model_busy();
      return (rx_q.size() > 0) || (rx_wait > 0) || fetch_busy ||
             (pend_ev.size() > 0) || (pend_drop_rdy.size() > 0);
   endfunction

   task automatic settle();
      int n;
      n = 0;
      while (model_busy() && n < 600) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 600) begin
         errors++;
         $display("FAIL settle: byte stream not consumed within %0d cycles", n);
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic feed(input logic [7:0] b);
      rx_q.push_back(b);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: run did not complete, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

   logic [31:0] d;

   initial begin
      rst        = 1'b0;
      bus.addr_i = 32'h0;
      bus.data_i = 32'h0;
      bus.sel_i  = 2'b11;
      bus.rd_i   = 1'b0;
      bus.we_i   = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_byte_rd", 32'(byte_rd_o), 32'd0);
      chk("rst_ack", 32'(bus.ack_o), 32'd0);
      chk("rst_data", bus.data_o, 32'd0);
      chk("rst_irq", 32'(interrupt), 32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Make and break of one key
      feed(8'h1C);
      feed(8'hF0); feed(8'h1C);
      settle();
      chk("mb_irq", 32'(interrupt), 32'd1);
      bus_rd(32'h0, d); chk("mb_make", d, 32'h8000_001C);
      bus_rd(32'h0, d); chk("mb_break", d, 32'h8000_021C);
      repeat (2) @(negedge clk);
      chk("mb_irq_low", 32'(interrupt), 32'd0);
      bus_rd(32'h0, d); chk("mb_empty", d, 32'h0);

      // Extended key make and break
      feed(8'hE0); feed(8'h75);
      feed(8'hE0); feed(8'hF0); feed(8'h75);
      settle();
      bus_rd(32'h0, d); chk("ext_make", d, 32'h8000_0175);
      bus_rd(32'h0, d); chk("ext_break", d, 32'h8000_0375);
      bus_rd(32'h0, d); chk("ext_empty", d, 32'h0);

      // Pause sequence collapses to one event
      feed(8'hE1); feed(8'h14); feed(8'h77); feed(8'hE1);
      feed(8'hF0); feed(8'h14); feed(8'hF0); feed(8'h77);
      settle();
      bus_rd(32'h0, d); chk("pause_ev", d, 32'h8000_01E1);
      bus_rd(32'h0, d); chk("pause_empty", d, 32'h0);
      feed(8'h1C);
      settle();
      bus_rd(32'h0, d); chk("pause_after", d, 32'h8000_001C);

      // Receiver error bytes and counter clear
      feed(8'h00); feed(8'hFF);
      settle();
      bus_rd(32'h4, d); chk("drop_two", d, 32'h0002_0000);
      bus_wr(32'h4, 32'h1);
      bus_rd(32'h4, d); chk("drop_clr", d, 32'h0);

      // Fill the FIFO with 5 bytes still pending in the receiver
      for (int i = 0; i < 21; i++) feed(8'(8'h15 + i));
      repeat (300) @(negedge clk);
      chk("fill_pending", 32'(rx_q.size()), 32'd5);
      bus_rd(32'h4, d); chk("fill_count", d, 32'h0000_0010);
      bus_rd(32'h0, d); chk("fill_pop", d, 32'h8000_0015);
      repeat (40) @(negedge clk);
      chk("fill_one_fetch", 32'(rx_q.size()), 32'd4);
      bus_rd(32'h4, d); chk("fill_refill", d, 32'h0000_0010);
      for (int i = 0; i < 16; i++) begin
         bus_rd(32'h0, d);
         chk("fill_drain", d, 32'h8000_0000 | 32'(8'h16 + i));
      end
      settle();
      for (int i = 0; i < 4; i++) begin
         bus_rd(32'h0, d);
         chk("fill_tail", d, 32'h8000_0000 | 32'(8'h26 + i));
      end

      // Typematic repeats
      feed(8'h1C); feed(8'h1C); feed(8'h1C); feed(8'hF0); feed(8'h1C);
      settle();
`ifdef PS2_KEYCODE_TYPEMATIC_FILTER_EN
      bus_rd(32'h0, d); chk("typ_make", d, 32'h8000_001C);
      bus_rd(32'h0, d); chk("typ_break", d, 32'h8000_021C);
`else
      for (int i = 0; i < 3; i++) begin
         bus_rd(32'h0, d); chk("typ_make", d, 32'h8000_001C);
      end
      bus_rd(32'h0, d); chk("typ_break", d, 32'h8000_021C);
`endif
      bus_rd(32'h0, d); chk("typ_empty", d, 32'h0);

      // Randomized byte stream and bus traffic, checked by the model every cycle
      for (int i = 0; i < 3000; i++) begin
         int r;
         @(negedge clk);
         bus.rd_i = 1'b0;
         bus.we_i = 1'b0;
         if (rx_q.size() < 4 && $urandom_range(0, 3) == 0) rx_q.push_back(rand_byte());
         r = int'($urandom_range(0, 99));
         if (r < 30) begin
            bus.addr_i = $urandom & 32'hFFFF_FFFB;
            bus.rd_i   = 1'b1;
         end else if (r < 40) begin
            bus.addr_i = $urandom | 32'h0000_0004;
            bus.rd_i   = 1'b1;
         end else if (r < 45) begin
            bus.addr_i = $urandom | 32'h0000_0004;
            bus.data_i = ($urandom & 32'hFFFF_FFFE) | 32'($urandom_range(0, 4) == 0);
            bus.we_i   = 1'b1;
         end else if (r < 48) begin
            bus.addr_i = $urandom & 32'hFFFF_FFFB;
            bus.data_i = $urandom;
            bus.we_i   = 1'b1;
         end
      end
      @(negedge clk);
      bus.rd_i = 1'b0;
      bus.we_i = 1'b0;

      // Drain everything that is still in flight
      begin
         int n;
         n = 0;
         while ((model_busy() || mfifo.size() > 0) && n < 3000) begin
            bus_rd(32'h0, d);
            n++;
         end
         checks++;
         if (n >= 3000) begin
            errors++;
            $display("FAIL drain: events still pending after %0d reads", n);
         end
      end
      repeat (4) @(negedge clk);
      chk("final_irq", 32'(interrupt), 32'd0);
      bus_rd(32'h0, d); chk("final_empty", d, 32'h0);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
